fifo_write_arbiter: RTL and testbench

//  Round-robin arbiter sharing the single FIFO write port (w_en/data_in) among NUM_REQ producers.

---
 rtl/fifo_write_arbiter.sv | 163 ++++++++++++++++
 tb/tb_fifo_write_arbiter.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_write_arbiter.sv
// Round-robin arbiter that shares one FIFO write port among NUM_REQ producers.
// The owner keeps the port for up to MAX_BURST words, and writes are throttled on full and almost_full.
module fifo_write_arbiter #(
  parameter int NUM_REQ   = 4,
  parameter int DATA_W    = 8,
  parameter int MAX_BURST = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  input  logic [NUM_REQ-1:0]        req_last,
  output logic [NUM_REQ-1:0]        ack,
  output logic [NUM_REQ-1:0]        grant,
  output logic                      stalled,
  output logic                      w_en,
  output logic [DATA_W-1:0]         data_in,
  input  logic                      full_flag,
  input  logic                      almost_full,
  output logic [1:0]                dbg_state
);

  // Handshake: a producer holds req[i] high with a valid word and req_last[i].
  // The word is consumed in the cycle where ack[i]=1 and is written to the FIFO
  // one cycle later. Requests from non-owners stay pending and are never acked.

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CNT_W = $clog2(MAX_BURST) + 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_OWN   = 2'd1,
    S_STALL = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   owner_q, owner_d;
  logic [IDX_W-1:0]   last_owner_q, last_owner_d;
  logic [CNT_W-1:0]   burst_cnt_q, burst_cnt_d;
  logic [NUM_REQ-1:0] grant_q, grant_d;
  logic               stalled_q, stalled_d;
  logic               w_en_q, w_en_d;
  logic [DATA_W-1:0]  data_in_q, data_in_d;

  logic               pick_valid;
  logic [IDX_W-1:0]   pick_idx;
  logic [IDX_W-1:0]   cand_idx;
  int unsigned        cand;
  logic               owner_req;
  logic               acc;
  logic               burst_end;
  logic [DATA_W-1:0]  owner_data;

  // The scan starts one past the last owner, so every requester gets a turn.
  always_comb begin
    pick_valid = 1'b0;
    pick_idx   = '0;
    cand       = 0;
    cand_idx   = '0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      cand     = (int'(last_owner_q) + i) % NUM_REQ;
      cand_idx = IDX_W'(cand);
      if (!pick_valid && req[cand_idx]) begin
        pick_valid = 1'b1;
        pick_idx   = cand_idx;
      end
    end
  end

  assign owner_req  = req[owner_q];
  assign owner_data = req_data[owner_q*DATA_W +: DATA_W];
  assign burst_end  = req_last[owner_q] || (burst_cnt_q == CNT_W'(MAX_BURST - 1));

  // Reset also blocks acceptance so that no word is lost while the block is in reset.
  assign acc = rst_n && (state_q == S_OWN) && owner_req && !full_flag &&
               !(almost_full && w_en_q);

  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    last_owner_d = last_owner_q;
    burst_cnt_d  = burst_cnt_q;
    grant_d      = grant_q;
    case (state_q)
      S_IDLE: begin
        grant_d = '0;
        if (pick_valid) begin
          owner_d     = pick_idx;
          grant_d     = NUM_REQ'(1) << pick_idx;
          burst_cnt_d = '0;
          state_d     = S_OWN;
        end
      end
      S_OWN: begin
        if (!owner_req) begin
          state_d      = S_IDLE;
          last_owner_d = owner_q;
          grant_d      = '0;
        end else if (full_flag) begin
          state_d = S_STALL;
        end else if (acc) begin
          if (burst_end) begin
            state_d      = S_IDLE;
            last_owner_d = owner_q;
            grant_d      = '0;
            burst_cnt_d  = '0;
          end else begin
            burst_cnt_d = burst_cnt_q + CNT_W'(1);
          end
        end
      end
      S_STALL: begin
        if (!owner_req) begin
          state_d      = S_IDLE;
          last_owner_d = owner_q;
          grant_d      = '0;
        end else if (!full_flag) begin
          state_d = S_OWN;
        end
      end
      default: begin
        state_d = S_IDLE;
        grant_d = '0;
      end
    endcase
  end

  always_comb begin
    w_en_d    = acc;
    data_in_d = acc ? owner_data : data_in_q;
    stalled_d = (state_d == S_STALL);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      owner_q      <= '0;
      last_owner_q <= IDX_W'(NUM_REQ - 1);
      burst_cnt_q  <= '0;
      grant_q      <= '0;
      stalled_q    <= 1'b0;
      w_en_q       <= 1'b0;
      data_in_q    <= '0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_owner_q <= last_owner_d;
      burst_cnt_q  <= burst_cnt_d;
      grant_q      <= grant_d;
      stalled_q    <= stalled_d;
      w_en_q       <= w_en_d;
      data_in_q    <= data_in_d;
    end
  end

  assign ack       = acc ? (NUM_REQ'(1) << owner_q) : '0;
  assign grant     = grant_q;
  assign stalled   = stalled_q;
  assign w_en      = w_en_q;
  assign data_in   = data_in_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_fifo_write_arbiter.sv
// Randomized and directed bench for fifo_write_arbiter.
// A behavioural owner/burst model predicts each cycle, and a word queue checks the write data.
module tb_fifo_write_arbiter;

  localparam int NR   = 4;
  localparam int DW   = 8;
  localparam int MAXB = 4;

  logic          clk;
  logic          rst_n;
  logic [NR-1:0] req;
  logic [NR*DW-1:0] req_data;
  logic [NR-1:0] req_last;
  logic [NR-1:0] ack;
  logic [NR-1:0] grant;
  logic          stalled;
  logic          w_en;
  logic [DW-1:0] data_in;
  logic          full_flag;
  logic          almost_full;
  logic [1:0]    dbg_state;

  fifo_write_arbiter #(.NUM_REQ(NR), .DATA_W(DW), .MAX_BURST(MAXB)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .req_data(req_data), .req_last(req_last),
    .ack(ack), .grant(grant), .stalled(stalled), .w_en(w_en), .data_in(data_in),
    .full_flag(full_flag), .almost_full(almost_full), .dbg_state(dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: owner index (-1 = nobody), words taken in this grant, stall flag.
  int            m_owner = -1;
  int            m_cnt   = 0;
  int            m_last  = NR - 1;
  bit            m_stall = 0;
  bit            m_wen   = 0;
  logic [DW-1:0] m_data  = '0;
  logic [DW-1:0] exp_q[$];

  logic [DW-1:0] pw [NR];
  logic [NR-1:0] obs_ack;
  logic          prev_wen;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // driver: apply one cycle of inputs, predict, check ack, then check the registered outputs
  task automatic step(input logic r, input logic [NR-1:0] rq, input logic [NR-1:0] lst,
                      input logic f, input logic a);
    logic [NR-1:0] e_ack;
    logic [NR-1:0] e_grant;
    logic [DW-1:0] w;
    bit found;
    int c;
    rst_n = r; req = rq; req_last = lst; full_flag = f; almost_full = a;
    for (int i = 0; i < NR; i++) req_data[i*DW +: DW] = pw[i];
    #1;
    e_ack = '0;
    found = 0;
    if (!r) begin
      m_owner = -1; m_cnt = 0; m_stall = 0; m_last = NR - 1; m_data = '0;
    end else if (m_owner < 0) begin
      for (int k = 1; k <= NR; k++) begin
        c = (m_last + k) % NR;
        if (!found && rq[c]) begin
          found = 1; m_owner = c; m_cnt = 0;
        end
      end
    end else if (!rq[m_owner]) begin
      m_last = m_owner; m_owner = -1; m_stall = 0;
    end else if (f) begin
      m_stall = 1;
    end else if (m_stall) begin
      m_stall = 0;
    end else if (!(a && m_wen)) begin
      e_ack[m_owner] = 1'b1;
      m_data = pw[m_owner];
      exp_q.push_back(pw[m_owner]);
      m_cnt++;
      if (lst[m_owner] || m_cnt == MAXB) begin
        m_last = m_owner; m_owner = -1;
      end
    end
    m_wen = (e_ack != '0);
    chk("ack", 32'(ack), 32'(e_ack));
    chk("ack_onehot0", 32'($onehot0(ack)), 32'd1);
    obs_ack = ack;
    @(posedge clk); #1;
    e_grant = (m_owner < 0) ? '0 : (NR'(1) << m_owner);
    chk("grant", 32'(grant), 32'(e_grant));
    chk("w_en", 32'(w_en), 32'(m_wen));
    chk("data_in", 32'(data_in), 32'(m_data));
    chk("stalled", 32'(stalled), 32'(m_stall));
    if (w_en === 1'b1) begin
      if (exp_q.size() == 0) begin
        chk("sb_empty", 32'd1, 32'd0);
      end else begin
        w = exp_q.pop_front();
        chk("sb_word", 32'(data_in), 32'(w));
      end
    end
  endtask

  initial begin
    int cnt;
    int budget;
    int idx;
    logic [DW-1:0] seq [3];
    logic [NR-1:0] rq;
    logic [NR-1:0] lst;
    for (int i = 0; i < NR; i++) pw[i] = 8'(i + 1);
    prev_wen = 1'b0;

    // 1: reset with everyone requesting
    for (int i = 0; i < 3; i++) step(1'b0, 4'b1111, 4'b0000, 1'b0, 1'b0);
    chk("rst_grant", 32'(grant), 32'd0);
    chk("rst_w_en", 32'(w_en), 32'd0);
    chk("rst_stalled", 32'(stalled), 32'd0);

    // 2: two constant requesters, full bursts
    cnt = 0;
    for (int i = 0; i < 20; i++) begin
      step(1'b1, 4'b0101, 4'b0000, 1'b0, 1'b0);
      if (i == 0) chk("rr_first", 32'(grant), 32'b0001);
      if (i >= 10 && w_en === 1'b1) cnt++;
      for (int j = 0; j < NR; j++) if (obs_ack[j]) pw[j] = 8'($urandom_range(0, 255));
    end
    chk("rr_wen_per10", 32'(cnt), 32'd8);

    // 3: short packet on requester 2
    step(1'b1, 4'b0000, 4'b0000, 1'b0, 1'b0);
    step(1'b1, 4'b0000, 4'b0000, 1'b0, 1'b0);
    seq[0] = 8'hA1; seq[1] = 8'hA2; seq[2] = 8'hA3;
    idx = 0; budget = 0; cnt = 0;
    while (idx < 3 && budget < 12) begin
      pw[2] = seq[idx];
      step(1'b1, 4'b0100, (idx == 2) ? 4'b0100 : 4'b0000, 1'b0, 1'b0);
      if (obs_ack[2]) begin idx++; cnt++; end
      budget++;
    end
    chk("pkt_acks", 32'(cnt), 32'd3);
    step(1'b1, 4'b0000, 4'b0000, 1'b0, 1'b0);
    chk("pkt_idle", 32'(grant), 32'd0);

    // 4: FIFO full after the second word of a burst
    cnt = 0; budget = 0;
    while (cnt < 2 && budget < 12) begin
      step(1'b1, 4'b0010, 4'b0000, 1'b0, 1'b0);
      if (obs_ack[1]) cnt++;
      budget++;
    end
    chk("full_pre_acks", 32'(cnt), 32'd2);
    cnt = 0;
    for (int i = 0; i < 5; i++) begin
      step(1'b1, 4'b0010, 4'b0000, 1'b1, 1'b0);
      if (obs_ack != '0) cnt++;
    end
    chk("full_no_ack", 32'(cnt), 32'd0);
    chk("full_stalled", 32'(stalled), 32'd1);
    chk("full_grant", 32'(grant), 32'b0010);
    cnt = 0; budget = 0;
    do begin
      step(1'b1, 4'b0010, 4'b0000, 1'b0, 1'b0);
      if (obs_ack[1]) cnt++;
      budget++;
    end while (grant !== '0 && budget < 12);
    chk("full_post_acks", 32'(cnt), 32'd2);

    // 5: almost full, single requester
    step(1'b1, 4'b0000, 4'b0000, 1'b0, 1'b0);
    prev_wen = 1'b0; cnt = 0;
    for (int i = 0; i < 16; i++) begin
      step(1'b1, 4'b0001, 4'b0000, 1'b0, 1'b1);
      chk("af_b2b", 32'(w_en && prev_wen), 32'd0);
      if (w_en === 1'b1) cnt++;
      prev_wen = w_en;
    end
    chk("af_some_writes", 32'(cnt > 0), 32'd1);

    // 6: reset in the middle of a burst on requester 3
    step(1'b1, 4'b0000, 4'b0000, 1'b0, 1'b0);
    budget = 0;
    do begin
      step(1'b1, 4'b1000, 4'b0000, 1'b0, 1'b0);
      budget++;
    end while (obs_ack[3] !== 1'b1 && budget < 12);
    chk("mid_owner3", 32'(grant), 32'b1000);
    step(1'b0, 4'b1000, 4'b0000, 1'b0, 1'b0);
    chk("mid_rst_grant", 32'(grant), 32'd0);
    chk("mid_rst_w_en", 32'(w_en), 32'd0);
    step(1'b1, 4'b1001, 4'b0000, 1'b0, 1'b0);
    chk("mid_first_grant", 32'(grant), 32'b0001);

    // randomized traffic
    for (int n = 0; n < 600; n++) begin
      rq  = '0;
      lst = '0;
      for (int j = 0; j < NR; j++) begin
        rq[j]  = ($urandom_range(0, 3) != 0);
        lst[j] = ($urandom_range(0, 3) == 0);
      end
      step(($urandom_range(0, 99) != 0), rq, lst,
           ($urandom_range(0, 7) == 0), ($urandom_range(0, 5) == 0));
      for (int j = 0; j < NR; j++) if (obs_ack[j]) pw[j] = 8'($urandom_range(0, 255));
    end

    // drain, then the write queue must be empty
    step(1'b1, 4'b0000, 4'b0000, 1'b0, 1'b0);
    step(1'b1, 4'b0000, 4'b0000, 1'b0, 1'b0);
    chk("sb_drained", 32'(exp_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
